// File: rtl/xor_reduce_pkg.sv
// Shared types and sizing helpers for the pipelined mux-built parity tree.
package xor_reduce_pkg;

  localparam int DEF_WIDTH         = 16;
  localparam int DEF_LVL_PER_STAGE = 2;
  localparam int DEF_CNT_W         = 8;

  // bit0 selects odd parity, bit1 selects check mode
  typedef enum logic [1:0] {
    GEN_EVEN = 2'd0,
    GEN_ODD  = 2'd1,
    CHK_EVEN = 2'd2,
    CHK_ODD  = 2'd3
  } mode_t;

  // Per-word sideband that travels alongside the partial XOR vector
  typedef struct packed {
    mode_t mode;
    logic  par;
  } tag_t;

  function automatic int stage_count(input int width, input int lvl_per_stage);
    return ($clog2(width) + lvl_per_stage - 1) / lvl_per_stage;
  endfunction

  function automatic int lvl_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/xor2_mux_cell.sv
// Two-input XOR assembled purely from 2:1 mux primitives and tie-offs.
module mux2 (
  input  logic d0,
  input  logic d1,
  input  logic s,
  output logic y
);
  assign y = s ? d1 : d0;
endmodule

module xor2_mux_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  logic a_n;

  // a_n = !a, then b picks between a and !a
  mux2 u_inv (.d0(1'b1), .d1(1'b0), .s(a), .y(a_n));
  mux2 u_sel (.d0(a),    .d1(a_n),  .s(b), .y(y));
endmodule

// File: rtl/xor_reduce_pipe.sv
// Pipelined parity generator/checker: mux-built XOR tree registered every
// LVL_PER_STAGE levels, global-stall handshake and saturating error counter.
module xor_reduce_pipe
  import xor_reduce_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int LVL_PER_STAGE = DEF_LVL_PER_STAGE,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int PW     = 1 << LEVELS;
  localparam int STAGES = stage_count(WIDTH, LVL_PER_STAGE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            adv;
  logic [STAGES:1] vld_pipe;
  tag_t            in_tag;
  logic [PW-1:0]   in_vec;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign in_tag    = '{mode: mode_t'(in_mode), par: in_par};
  assign in_vec    = PW'(in_data);

  // Bubbles are kept: the whole pipe advances or holds together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * LVL_PER_STAGE;
    localparam int HI = lvl_min((s + 1) * LVL_PER_STAGE, LEVELS);
    localparam int NL = HI - LO;
    localparam int IW = PW >> LO;
    localparam int OW = PW >> HI;

    logic [IW-1:0] d_in;
    logic [OW-1:0] d_out;
    tag_t          tag_in;
    logic          ld;

    if (s == 0) begin : g_src
      assign d_in   = in_vec;
      assign tag_in = in_tag;
      assign ld     = in_valid && adv;
    end else begin : g_src
      assign d_in   = g_st[s-1].g_reg.vec_q;
      assign tag_in = g_st[s-1].g_reg.tag_q;
      assign ld     = vld_pipe[s] && adv;
    end

    for (genvar k = 0; k < NL; k++) begin : g_lv
      logic [(IW>>k)-1:0]     a;
      logic [(IW>>(k+1))-1:0] y;

      if (k == 0) begin : g_a
        assign a = d_in;
      end else begin : g_a
        assign a = g_lv[k-1].y;
      end

      for (genvar i = 0; i < (IW >> (k + 1)); i++) begin : g_x
        xor2_mux_cell u_xor (.a(a[2*i]), .b(a[2*i+1]), .y(y[i]));
      end
    end

    assign d_out = g_lv[NL-1].y;

    // Only valid words load, so X on idle inputs never enters the pipe
    if (s < STAGES - 1) begin : g_reg
      logic [OW-1:0] vec_q;
      tag_t          tag_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vec_q <= '0;
          tag_q <= '0;
        end else if (ld) begin
          vec_q <= d_out;
          tag_q <= tag_in;
        end
      end
    end else begin : g_out
      logic par_c;
      logic mis_c;

      xor2_mux_cell u_odd (.a(d_out[0]), .b(tag_in.mode[0]), .y(par_c));
      xor2_mux_cell u_chk (.a(par_c),    .b(tag_in.par),     .y(mis_c));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_par <= 1'b0;
          out_err <= 1'b0;
        end else if (ld) begin
          out_par <= par_c;
          out_err <= mis_c && tag_in.mode[1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xor_reduce_pipe.sv
// Directed bench for xor_reduce_pipe at WIDTH=16, LVL_PER_STAGE=2, CNT_W=4.
module tb_xor_reduce_pipe;
  import xor_reduce_pkg::*;

  localparam int WIDTH = 16;
  localparam int LVL   = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_mode = 2'b00;
  logic             in_par = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_par;
  logic             out_err;
  logic [CNT_W-1:0] err_cnt;
  logic             err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int sent, got;
  logic exp_rdy;
  logic [7:0] exp_par;

  always #5 clk = ~clk;

  xor_reduce_pipe #(.WIDTH(WIDTH), .LVL_PER_STAGE(LVL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_par(out_par), .out_err(out_err),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input mode_t m, input logic p);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_par   = p;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // reset state
    #12;
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_par", out_par, 1'b0);
    chk("rst_err", out_err, 1'b0);
    chk("rst_cnt", err_cnt, 4'd0);
    idle();
    rst_n = 1'b1;
    tick();

    // generate even, latency 2
    drive(16'h0001, GEN_EVEN, 1'b0);
    tick(); idle();
    chk("gen_lat1_vld", out_valid, 1'b0);
    tick();
    chk("gen_vld", out_valid, 1'b1);
    chk("gen_par", out_par, 1'b1);
    chk("gen_err", out_err, 1'b0);
    chk("gen_cnt", err_cnt, 4'd0);
    tick();
    chk("gen_bubble", out_valid, 1'b0);

    // generate odd, back-to-back
    drive(16'hFFFF, GEN_ODD, 1'b0);
    tick();
    drive(16'h8001, GEN_ODD, 1'b0);
    tick(); idle();
    chk("odd1_vld", out_valid, 1'b1);
    chk("odd1_par", out_par, 1'b1);
    tick();
    chk("odd2_vld", out_valid, 1'b1);
    chk("odd2_par", out_par, 1'b1);
    tick();

    // check mode error and no-error
    drive(16'h0003, CHK_EVEN, 1'b1);
    tick(); idle(); tick();
    chk("chk_par", out_par, 1'b0);
    chk("chk_err", out_err, 1'b1);
    chk("chk_cnt0", err_cnt, 4'd0);
    tick();
    chk("chk_cnt1", err_cnt, 4'd1);
    drive(16'h0003, CHK_EVEN, 1'b0);
    tick(); idle(); tick();
    chk("chk_ok_err", out_err, 1'b0);
    tick();
    chk("chk_ok_cnt", err_cnt, 4'd1);

    // check odd matching parity, then generate mode ignores in_par
    drive(16'h0007, CHK_ODD, 1'b0);
    tick(); idle(); tick();
    chk("chkodd_par", out_par, 1'b0);
    chk("chkodd_err", out_err, 1'b0);
    tick();
    drive(16'h0001, GEN_EVEN, 1'b0);
    tick(); idle(); tick();
    chk("gen_ign_par", out_par, 1'b1);
    chk("gen_ign_err", out_err, 1'b0);
    tick();
    chk("gen_ign_cnt", err_cnt, 4'd1);

    // backpressure: out_ready low for cycles 3..7
    exp_par = 8'b1100_1011;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      exp_rdy   = !(c >= 3 && c <= 7);
      out_ready = exp_rdy;
      if (sent < 8) drive(16'(sent + 1), GEN_EVEN, 1'b0);
      else idle();
      #1;
      chk("bp_in_ready", in_ready, exp_rdy);
      if (c >= 3 && c <= 7) chk("bp_hold", {out_valid, out_par}, 2'b11);
      if (out_valid && out_ready) begin
        chk("bp_par", out_par, exp_par[got]);
        got++;
      end
      if (exp_rdy && sent < 8) sent++;
      tick();
    end
    chk("bp_count", got, 8);
    out_ready = 1'b1;
    idle(); tick(); tick();

    // saturation: 20 errors from count 1
    for (int i = 0; i < 20; i++) begin
      drive(16'h0001, CHK_EVEN, 1'b0);
      tick();
    end
    idle(); tick(); tick(); tick();
    chk("sat_cnt", err_cnt, 4'd15);

    // clear wins over an error transfer in the same cycle
    drive(16'h0001, CHK_EVEN, 1'b0);
    tick(); idle(); tick();
    chk("clr_pre_err", out_err, 1'b1);
    chk("clr_pre_cnt", err_cnt, 4'd15);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_cnt", err_cnt, 4'd0);

    // async reset mid-stream
    drive(16'h0001, CHK_EVEN, 1'b0);
    tick(); tick(); tick();
    chk("pre_rst_vld", out_valid, 1'b1);
    chk("pre_rst_err", out_err, 1'b1);
    chk("pre_rst_cnt", err_cnt, 4'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", out_valid, 1'b0);
    chk("arst_par", out_par, 1'b0);
    chk("arst_err", out_err, 1'b0);
    chk("arst_cnt", err_cnt, 4'd0);
    chk("arst_rdy", in_ready, 1'b1);
    idle();
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    drive(16'h0003, GEN_ODD, 1'b0);
    tick(); idle();
    chk("post_lat1_vld", out_valid, 1'b0);
    tick();
    chk("post_vld", out_valid, 1'b1);
    chk("post_par", out_par, 1'b1);
    chk("post_err", out_err, 1'b0);
    chk("post_cnt", err_cnt, 4'd0);
    tick();
    chk("post_drain", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
